// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the configurable synchronous FIFO.
package fifo_pkg;

    localparam int unsigned FWFT_OFF      = 0;
    localparam int unsigned FWFT_ON       = 1;
    localparam int unsigned DEF_AE_TH     = 2;
    localparam int unsigned DEF_AF_MARGIN = 2;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned FIFO_DEPTH = 32,
    localparam int unsigned AW         = clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Store the write word; contents survive flush and reset by design.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_cfg.sv
// Configurable single-clock FIFO with optional first-word-fall-through read,
// fill count, threshold flags, sticky error flags and synchronous flush.
module fifo_sync_cfg
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned FIFO_DEPTH = 32,
    parameter  int unsigned AF_TH      = FIFO_DEPTH - DEF_AF_MARGIN,
    parameter  int unsigned AE_TH      = DEF_AE_TH,
    parameter  int unsigned FWFT       = FWFT_OFF,
    localparam int unsigned CW         = clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PW = clog2(FIFO_DEPTH);

    // Reject parameter sets that make the flags meaningless.
    if (AF_TH > FIFO_DEPTH || AE_TH >= FIFO_DEPTH || FIFO_DEPTH < 2 || DATA_WIDTH < 1)
    begin : g_param_err
        $error("fifo_sync_cfg: illegal parameter set");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  ae_q, ae_d, af_q, af_d;
    logic                  wr_acc_c, rd_acc_c;
    logic [DATA_WIDTH-1:0] ram_rdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_c),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Next-state: accept/reject requests, update pointers, count, errors and flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        wr_acc_c   = wr && (!full_q || rd);
        rd_acc_c   = rd && !empty_q;

        if (flush) begin
            wr_acc_c = 1'b0;
            rd_acc_c = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc_c) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_acc_c) begin
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                dout_d     = ram_rdata;
                rd_valid_d = 1'b1;
            end
            count_d = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);
            if (wr && full_q && !rd) ovf_d = 1'b1;
            if (rd && empty_q)       udf_d = 1'b1;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(FIFO_DEPTH));
        af_d    = (count_d >= CW'(AF_TH));
        ae_d    = (count_d <= CW'(AE_TH));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ae_q       <= 1'b1;
            af_q       <= (AF_TH == 0);
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ae_q       <= ae_d;
            af_q       <= af_d;
        end
    end

    // FWFT exposes the head word directly; standard mode uses the read register.
    if (FWFT == FWFT_ON) begin : g_fwft
        assign data_out = empty_q ? '0 : ram_rdata;
        assign rd_valid = !empty_q;
    end else begin : g_std
        assign data_out = dout_q;
        assign rd_valid = rd_valid_q;
    end

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Randomized self-checking bench: standard-mode 32-deep FIFO and FWFT 5-deep FIFO
// against a queue-based reference model.
module tb_fifo_sync_cfg;
    import fifo_pkg::*;

    localparam int unsigned DA  = 32;
    localparam int unsigned DB  = 5;
    localparam int unsigned CWA = clog2(DA + 1);
    localparam int unsigned CWB = clog2(DB + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic           wr_a, rd_a, flush_a;
    logic [7:0]     din_a, dout_a;
    logic           rv_a, emp_a, ae_a, af_a, full_a, ov_a, ud_a;
    logic [CWA-1:0] cnt_a;

    logic           wr_b, rd_b, flush_b;
    logic [7:0]     din_b, dout_b;
    logic           rv_b, emp_b, ae_b, af_b, full_b, ov_b, ud_b;
    logic [CWB-1:0] cnt_b;

    fifo_sync_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr(wr_a), .rd(rd_a), .flush(flush_a),
        .data_in(din_a), .data_out(dout_a), .rd_valid(rv_a), .count(cnt_a),
        .empty(emp_a), .almost_empty(ae_a), .almost_full(af_a), .full(full_a),
        .overflow(ov_a), .underflow(ud_a)
    );

    fifo_sync_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(DB), .FWFT(FWFT_ON)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr(wr_b), .rd(rd_b), .flush(flush_b),
        .data_in(din_b), .data_out(dout_b), .rd_valid(rv_b), .count(cnt_b),
        .empty(emp_b), .almost_empty(ae_b), .almost_full(af_b), .full(full_b),
        .overflow(ov_b), .underflow(ud_b)
    );

    always #5 clk = ~clk;

    wire [CWA+14:0] act_a = {cnt_a, dout_a, rv_a, emp_a, ae_a, af_a, full_a, ov_a, ud_a};
    wire [CWB+14:0] act_b = {cnt_b, dout_b, rv_b, emp_b, ae_b, af_b, full_b, ov_b, ud_b};

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue contents plus sticky flags and the read register.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       ova, uda, rva, ovb, udb;
    logic [7:0] douta;

    task automatic model_reset();
        qa.delete(); qb.delete();
        ova = 0; uda = 0; rva = 0; douta = 8'h00; ovb = 0; udb = 0;
    endtask

    task automatic model_step_a();
        bit was_full, was_empty;
        was_full  = (qa.size() == DA);
        was_empty = (qa.size() == 0);
        if (flush_a) begin
            qa.delete(); ova = 0; uda = 0; rva = 0; douta = 8'h00;
        end else begin
            rva = 0;
            if (wr_a && was_full && !rd_a) ova = 1;
            if (rd_a && was_empty) uda = 1;
            if (rd_a && !was_empty) begin douta = qa.pop_front(); rva = 1; end
            if (wr_a && (!was_full || rd_a)) qa.push_back(din_a);
        end
    endtask

    task automatic model_step_b();
        bit was_full, was_empty;
        logic [7:0] junk;
        was_full  = (qb.size() == DB);
        was_empty = (qb.size() == 0);
        if (flush_b) begin
            qb.delete(); ovb = 0; udb = 0;
        end else begin
            if (wr_b && was_full && !rd_b) ovb = 1;
            if (rd_b && was_empty) udb = 1;
            if (rd_b && !was_empty) junk = qb.pop_front();
            if (wr_b && (!was_full || rd_b)) qb.push_back(din_b);
        end
    endtask

    function automatic logic [CWA+14:0] exp_a();
        int n = qa.size();
        return {CWA'(n), douta, rva, n == 0, n <= 2, n >= DA - 2, n == DA, ova, uda};
    endfunction

    function automatic logic [CWB+14:0] exp_b();
        int n = qb.size();
        logic [7:0] head = (n != 0) ? qb[0] : 8'h00;
        return {CWB'(n), head, n != 0, n == 0, n <= 2, n >= DB - 2, n == DB, ovb, udb};
    endfunction

    task automatic idle();
        wr_a = 0; rd_a = 0; flush_a = 0; din_a = 8'h00;
        wr_b = 0; rd_b = 0; flush_b = 0; din_b = 8'h00;
    endtask

    // One clock: DUTs and model advance on the same sampled inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            model_step_a();
            model_step_b();
        end
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (act_a !== {CWA'(0), 8'h00, 7'b0110000}) begin
            n_fail++; $display("FAIL reset_a: got %h expected %h", act_a, {CWA'(0), 8'h00, 7'b0110000});
        end
        n_cmp++;
        if (act_b !== {CWB'(0), 8'h00, 7'b0110000}) begin
            n_fail++; $display("FAIL reset_b: got %h expected %h", act_b, {CWB'(0), 8'h00, 7'b0110000});
        end
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 32; i++) begin
            wr_a = 1; din_a = 8'(i);
            tick();
            n_cmp++;
            if (act_a !== exp_a()) begin
                n_fail++; $display("FAIL fill[%0d]: got %h expected %h", i, act_a, exp_a());
            end
            n_cmp++;
            if (af_a !== (i + 1 >= 30)) begin
                n_fail++; $display("FAIL almost_full[%0d]: got %b expected %b", i, af_a, i + 1 >= 30);
            end
        end
        din_a = 8'hEE;
        tick();
        idle();
        n_cmp++;
        if ({ov_a, full_a, cnt_a} !== {1'b1, 1'b1, CWA'(32)}) begin
            n_fail++; $display("FAIL overflow: got %b%b/%0d expected 11/32", ov_a, full_a, cnt_a);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 32; i++) begin
            rd_a = 1;
            tick();
            n_cmp++;
            if (dout_a !== 8'(i) || rv_a !== 1'b1) begin
                n_fail++; $display("FAIL drain[%0d]: got %h/%b expected %h/1", i, dout_a, rv_a, 8'(i));
            end
            n_cmp++;
            if (act_a !== exp_a()) begin
                n_fail++; $display("FAIL drain_state[%0d]: got %h expected %h", i, act_a, exp_a());
            end
        end
        tick();
        idle();
        n_cmp++;
        if ({ud_a, rv_a, dout_a, cnt_a} !== {1'b1, 1'b0, 8'h1F, CWA'(0)}) begin
            n_fail++; $display("FAIL underflow: got %b %b %h %0d expected 1 0 1f 0", ud_a, rv_a, dout_a, cnt_a);
        end
    endtask

    task automatic test_simul_full_empty();
        logic [7:0] first;
        flush_a = 1; tick(); idle();
        for (int i = 0; i < 32; i++) begin
            wr_a = 1; din_a = 8'($urandom);
            if (i == 0) first = din_a;
            tick();
        end
        wr_a = 1; rd_a = 1; din_a = 8'h55;
        tick();
        idle();
        n_cmp++;
        if ({dout_a, cnt_a, ov_a, full_a} !== {first, CWA'(32), 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL full_wr_rd: got %h/%0d/%b/%b expected %h/32/0/1", dout_a, cnt_a, ov_a, full_a, first);
        end
        for (int i = 0; i < 32; i++) begin
            rd_a = 1;
            tick();
            n_cmp++;
            if (act_a !== exp_a()) begin
                n_fail++; $display("FAIL drain2[%0d]: got %h expected %h", i, act_a, exp_a());
            end
        end
        n_cmp++;
        if (dout_a !== 8'h55) begin
            n_fail++; $display("FAIL last_word: got %h expected 55", dout_a);
        end
        wr_a = 1; rd_a = 1; din_a = 8'h77;
        tick();
        idle();
        n_cmp++;
        if ({cnt_a, ud_a, rv_a} !== {CWA'(1), 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL empty_wr_rd: got %0d/%b/%b expected 1/1/0", cnt_a, ud_a, rv_a);
        end
    endtask

    task automatic test_flush();
        flush_a = 1; tick(); idle();
        for (int i = 0; i < 33; i++) begin
            wr_a = 1; din_a = 8'($urandom); tick();
        end
        idle();
        for (int i = 0; i < 22; i++) begin
            rd_a = 1; tick();
        end
        idle();
        n_cmp++;
        if ({cnt_a, ov_a} !== {CWA'(10), 1'b1}) begin
            n_fail++; $display("FAIL pre_flush: got %0d/%b expected 10/1", cnt_a, ov_a);
        end
        flush_a = 1; wr_a = 1; din_a = 8'h99;
        tick();
        idle();
        n_cmp++;
        if (act_a !== {CWA'(0), 8'h00, 7'b0110000}) begin
            n_fail++; $display("FAIL flush: got %h expected %h", act_a, {CWA'(0), 8'h00, 7'b0110000});
        end
        wr_a = 1; din_a = 8'h42; tick(); idle();
        rd_a = 1; tick(); idle();
        n_cmp++;
        if ({dout_a, rv_a, cnt_a} !== {8'h42, 1'b1, CWA'(0)}) begin
            n_fail++; $display("FAIL post_flush: got %h/%b/%0d expected 42/1/0", dout_a, rv_a, cnt_a);
        end
    endtask

    task automatic test_reset_midburst();
        flush_a = 1; tick(); idle();
        for (int i = 0; i < 17; i++) begin
            wr_a = 1; din_a = 8'($urandom); tick();
        end
        n_cmp++;
        if (cnt_a !== CWA'(17)) begin
            n_fail++; $display("FAIL midburst_count: got %0d expected 17", cnt_a);
        end
        wr_a = 1; rd_a = 1; din_a = 8'hAA;
        #2;
        rst_n = 0;
        #1;
        idle();
        model_reset();
        n_cmp++;
        if (act_a !== {CWA'(0), 8'h00, 7'b0110000}) begin
            n_fail++; $display("FAIL async_reset_a: got %h expected %h", act_a, {CWA'(0), 8'h00, 7'b0110000});
        end
        n_cmp++;
        if (act_b !== {CWB'(0), 8'h00, 7'b0110000}) begin
            n_fail++; $display("FAIL async_reset_b: got %h expected %h", act_b, {CWB'(0), 8'h00, 7'b0110000});
        end
        tick();
        @(negedge clk);
        rst_n = 1;
        wr_a = 1; din_a = 8'h3C; tick(); idle();
        rd_a = 1; tick(); idle();
        n_cmp++;
        if ({dout_a, rv_a, cnt_a} !== {8'h3C, 1'b1, CWA'(0)}) begin
            n_fail++; $display("FAIL post_reset_rw: got %h/%b/%0d expected 3c/1/0", dout_a, rv_a, cnt_a);
        end
    endtask

    task automatic test_fwft();
        flush_b = 1; tick(); idle();
        wr_b = 1; din_b = 8'hA1; tick(); idle();
        n_cmp++;
        if ({dout_b, rv_b, cnt_b} !== {8'hA1, 1'b1, CWB'(1)}) begin
            n_fail++; $display("FAIL fwft_fall: got %h/%b/%0d expected a1/1/1", dout_b, rv_b, cnt_b);
        end
        tick();
        n_cmp++;
        if (dout_b !== 8'hA1) begin
            n_fail++; $display("FAIL fwft_hold: got %h expected a1", dout_b);
        end
        for (int k = 0; k < 12; k++) begin
            idle();
            if (k % 2 == 0) begin wr_b = 1; din_b = 8'($urandom); end
            else rd_b = 1;
            if (k % 4 == 1) begin wr_b = 1; din_b = 8'($urandom); end
            tick();
            n_cmp++;
            if (act_b !== exp_b()) begin
                n_fail++; $display("FAIL fwft_op[%0d]: got %h expected %h", k, act_b, exp_b());
            end
        end
        idle();
    endtask

    task automatic test_random();
        int wp, rp;
        for (int c = 0; c < 800; c++) begin
            wp = ((c / 100) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            wr_a = ($urandom_range(0, 99) < wp); rd_a = ($urandom_range(0, 99) < rp);
            flush_a = ($urandom_range(0, 99) < 2); din_a = 8'($urandom);
            wr_b = ($urandom_range(0, 99) < 50); rd_b = ($urandom_range(0, 99) < 50);
            flush_b = ($urandom_range(0, 99) < 2); din_b = 8'($urandom);
            tick();
            n_cmp++;
            if (act_a !== exp_a()) begin
                n_fail++; $display("FAIL rand_a[%0d]: got %h expected %h", c, act_a, exp_a());
            end
            n_cmp++;
            if (act_b !== exp_b()) begin
                n_fail++; $display("FAIL rand_b[%0d]: got %h expected %h", c, act_b, exp_b());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simul_full_empty();
        test_flush();
        test_reset_midburst();
        test_fwft();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
